mac_aging_table: RTL and testbench
==================================

MAC_AGING_TABLE -- requirements
Module: mac_aging_table

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of switch ports (>=2); PW = $clog2(NUM_PORTS).
REQ-002 SHALL have parameter NUM_ENTRIES, default 16, table depth (>=2, power of two); IW = $clog2(NUM_ENTRIES).
REQ-003 SHALL have parameter AGE_WIDTH, default 4, age counter width; AGE_MAX = all ones.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-006 Ports: learn_req_i in 1, learn strobe; learn_address_i in 48, source MAC; learn_port_i in PW, ingress port.
REQ-007 Ports: lookup_req_i in 1, lookup strobe; lookup_address_i in 48, destination MAC.
REQ-008 Ports: lookup_valid_o out 1, result strobe; lookup_hit_o out 1, match found; lookup_port_o out PW, matched port.
REQ-009 Ports: age_tick_i in 1, aging-period pulse; flush_req_i in 1, flush strobe; flush_port_i in PW, port to flush.
REQ-010 Ports: busy_o out 1, scan in progress; evict_o out 1, eviction pulse; entry_count_o out $clog2(NUM_ENTRIES+1), valid entries.

Function
REQ-011 Each entry SHALL hold valid, 48-bit address, PW-bit port, AGE_WIDTH-bit age.
REQ-012 Lookup: lookup_valid_o SHALL pulse exactly one cycle after lookup_req_i; hit -> lookup_hit_o=1, lookup_port_o=entry port; miss -> lookup_hit_o=0, lookup_port_o=0.
REQ-013 Lookup SHALL see table state before any same-cycle learn/scan update; lookup SHALL NOT modify age.
REQ-014 Learn, address present with same port: SHALL refresh age to AGE_MAX.
REQ-015 Learn, address present with different port (station move): SHALL overwrite port in place and refresh age; no duplicate entries ever exist.
REQ-016 Learn, address absent, free entry exists: SHALL write the lowest-index invalid entry with age AGE_MAX.
REQ-017 Learn, address absent, table full: SHALL replace the entry with smallest age (ties -> lowest index) and pulse evict_o one cycle.
REQ-018 Learn and lookup SHALL be accepted every cycle in every FSM state.
REQ-019 FSM states: IDLE, AGE_SCAN, FLUSH_SCAN; busy_o=1 in both scan states.
REQ-020 IDLE: flush_req_i -> FLUSH_SCAN; else age_tick_i -> AGE_SCAN; flush_req_i and age_tick_i together -> flush wins, tick dropped.
REQ-021 Scan SHALL visit one entry per cycle, index 0..NUM_ENTRIES-1, returning to IDLE after the last index (NUM_ENTRIES cycles busy).
REQ-022 AGE_SCAN: valid entry with age>1 -> age-1; age==1 -> invalidate; invalid entries untouched.
REQ-023 FLUSH_SCAN: valid entry whose port equals flush_port_i latched at start -> invalidate.
REQ-024 age_tick_i and flush_req_i while busy_o=1 SHALL be ignored.
REQ-025 Learn writing the entry under scan in the same cycle SHALL win (entry valid, new port, age AGE_MAX).
REQ-026 entry_count_o SHALL equal registered count of valid entries, updated the cycle after the causing event, never exceeding NUM_ENTRIES.
REQ-027 Age arithmetic SHALL saturate; no wrap of age or scan index beyond NUM_ENTRIES-1.

Reset
REQ-028 rst=1 at clk edge SHALL clear all valid bits, FSM to IDLE, and all outputs to 0 (lookup_valid_o, lookup_hit_o, lookup_port_o, busy_o, evict_o, entry_count_o).
REQ-029 rst mid-scan SHALL abort the scan; address/port/age storage need not be cleared.

Verification
REQ-030 Learn A=0x001122334455 port 2, lookup A next cycle -> lookup_valid_o=1, hit=1, port=2 one cycle after request; lookup unknown B -> hit=0, port=0.
REQ-031 Learn A port 1 then A port 3 -> entry_count_o stays 1; lookup A -> port 3.
REQ-032 AGE_WIDTH=2: learn A, issue 3 age ticks each followed by full scan -> A present after 2, lookup miss after 3, entry_count_o=0.
REQ-033 NUM_ENTRIES=4: fill 4 entries, age once, refresh entries 1-3 via learn, learn new E -> evict_o pulses, E in index 0, count=4.
REQ-034 Entries on ports 0,1,0,2; flush port 0 -> busy_o high 4 cycles, count 4->2; tick/flush during scan ignored.
REQ-035 Assert rst during AGE_SCAN -> next cycle busy_o=0, entry_count_o=0, all lookups miss.

Source files
------------

// File: rtl/mac_aging_table.sv
// MAC learning table with per-entry aging, station-move handling and port flush.
// Lookups return one cycle later and always see the table as it was before that cycle's updates.
module mac_aging_table #(
  parameter int NUM_PORTS   = 4,
  parameter int NUM_ENTRIES = 16,
  parameter int AGE_WIDTH   = 4,
  localparam int PW = $clog2(NUM_PORTS),
  localparam int IW = $clog2(NUM_ENTRIES),
  localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          learn_req_i,
  input  logic [47:0]   learn_address_i,
  input  logic [PW-1:0] learn_port_i,
  input  logic          lookup_req_i,
  input  logic [47:0]   lookup_address_i,
  output logic          lookup_valid_o,
  output logic          lookup_hit_o,
  output logic [PW-1:0] lookup_port_o,
  input  logic          age_tick_i,
  input  logic          flush_req_i,
  input  logic [PW-1:0] flush_port_i,
  output logic          busy_o,
  output logic          evict_o,
  output logic [CW-1:0] entry_count_o
);

  // state      | meaning
  // IDLE       | no scan running; tick or flush request starts one
  // AGE_SCAN   | one entry per cycle: decrement age, invalidate at age 1
  // FLUSH_SCAN | one entry per cycle: invalidate entries on the latched port
  typedef enum logic [1:0] {IDLE, AGE_SCAN, FLUSH_SCAN} state_t;

  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_ONE  = AGE_WIDTH'(1);
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_ENTRIES - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        flush_port_q, flush_port_d;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [47:0]            addr_q [NUM_ENTRIES];
  logic [47:0]            addr_d [NUM_ENTRIES];
  logic [PW-1:0]          port_q [NUM_ENTRIES];
  logic [PW-1:0]          port_d [NUM_ENTRIES];
  logic [AGE_WIDTH-1:0]   age_q  [NUM_ENTRIES];
  logic [AGE_WIDTH-1:0]   age_d  [NUM_ENTRIES];

  logic [CW-1:0]        count_q, count_d;
  logic                 evict_q, evict_d;
  logic                 lk_valid_q, lk_hit_q;
  logic [PW-1:0]        lk_port_q;

  logic                 lk_match;
  logic [PW-1:0]        lk_match_port;
  logic                 ln_hit, ln_free;
  logic [IW-1:0]        ln_hit_idx, ln_free_idx, min_idx, wr_idx;
  logic [AGE_WIDTH-1:0] min_age;

  always_comb begin
    lk_match      = 1'b0;
    lk_match_port = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && addr_q[i] == lookup_address_i) begin
        lk_match      = 1'b1;
        lk_match_port = port_q[i];
      end
    end
  end

  // Descending walk leaves the lowest matching / free index selected.
  always_comb begin
    ln_hit      = 1'b0;
    ln_hit_idx  = '0;
    ln_free     = 1'b0;
    ln_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && addr_q[i] == learn_address_i) begin
        ln_hit     = 1'b1;
        ln_hit_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        ln_free     = 1'b1;
        ln_free_idx = IW'(i);
      end
    end
  end

  // Replacement victim: strictly-smaller compare keeps the lowest index on ties.
  always_comb begin
    min_idx = '0;
    min_age = age_q[0];
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      if (age_q[i] < min_age) begin
        min_age = age_q[i];
        min_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    flush_port_d = flush_port_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (flush_req_i) begin
          state_d      = FLUSH_SCAN;
          flush_port_d = flush_port_i;
        end else if (age_tick_i) begin
          state_d = AGE_SCAN;
        end
      end
      AGE_SCAN, FLUSH_SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Scan update first, then learn, so a learn to the scanned entry overrides it.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    port_d  = port_q;
    age_d   = age_q;
    evict_d = 1'b0;
    wr_idx  = '0;

    if (state_q == AGE_SCAN && valid_q[idx_q]) begin
      if (age_q[idx_q] > AGE_ONE) begin
        age_d[idx_q] = age_q[idx_q] - AGE_ONE;
      end else if (age_q[idx_q] == AGE_ONE) begin
        valid_d[idx_q] = 1'b0;
      end
    end

    if (state_q == FLUSH_SCAN && valid_q[idx_q] && port_q[idx_q] == flush_port_q) begin
      valid_d[idx_q] = 1'b0;
    end

    if (learn_req_i) begin
      if (ln_hit) begin
        wr_idx = ln_hit_idx;
      end else if (ln_free) begin
        wr_idx = ln_free_idx;
      end else begin
        wr_idx  = min_idx;
        evict_d = 1'b1;
      end
      valid_d[wr_idx] = 1'b1;
      addr_d[wr_idx]  = learn_address_i;
      port_d[wr_idx]  = learn_port_i;
      age_d[wr_idx]   = AGE_MAX;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      flush_port_q <= '0;
      valid_q      <= '0;
      count_q      <= '0;
      evict_q      <= 1'b0;
      lk_valid_q   <= 1'b0;
      lk_hit_q     <= 1'b0;
      lk_port_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      flush_port_q <= flush_port_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      evict_q      <= evict_d;
      lk_valid_q   <= lookup_req_i;
      lk_hit_q     <= lookup_req_i & lk_match;
      lk_port_q    <= (lookup_req_i && lk_match) ? lk_match_port : '0;
    end
  end

  // Entry payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    port_q <= port_d;
    age_q  <= age_d;
  end

  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_hit_q;
  assign lookup_port_o  = lk_port_q;
  assign busy_o         = (state_q != IDLE);
  assign evict_o        = evict_q;
  assign entry_count_o  = count_q;

endmodule

// File: tb/tb_mac_aging_table.sv
// Self-checking bench for mac_aging_table (4 entries, 2-bit age): lookup results are
// scoreboarded against expectations queued when each lookup is issued.
module tb_mac_aging_table;
  localparam int NP = 4;
  localparam int NE = 4;
  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        learn_req_i = 1'b0;
  logic [47:0] learn_address_i = '0;
  logic [1:0]  learn_port_i = '0;
  logic        lookup_req_i = 1'b0;
  logic [47:0] lookup_address_i = '0;
  logic        lookup_valid_o, lookup_hit_o;
  logic [1:0]  lookup_port_o;
  logic        age_tick_i = 1'b0;
  logic        flush_req_i = 1'b0;
  logic [1:0]  flush_port_i = '0;
  logic        busy_o, evict_o;
  logic [2:0]  entry_count_o;

  mac_aging_table #(.NUM_PORTS(NP), .NUM_ENTRIES(NE), .AGE_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .learn_req_i(learn_req_i), .learn_address_i(learn_address_i), .learn_port_i(learn_port_i),
    .lookup_req_i(lookup_req_i), .lookup_address_i(lookup_address_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o), .lookup_port_o(lookup_port_o),
    .age_tick_i(age_tick_i), .flush_req_i(flush_req_i), .flush_port_i(flush_port_i),
    .busy_o(busy_o), .evict_o(evict_o), .entry_count_o(entry_count_o)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] A  = 48'h001122334455;
  localparam logic [47:0] B  = 48'h0000DEADBEEF;
  localparam logic [47:0] C  = 48'h00AABBCCDDEE;
  localparam logic [47:0] A0 = 48'h020000000000;
  localparam logic [47:0] A1 = 48'h020000000001;
  localparam logic [47:0] A2 = 48'h020000000002;
  localparam logic [47:0] A3 = 48'h020000000003;
  localparam logic [47:0] E  = 48'h0E0E0E0E0E0E;
  localparam logic [47:0] F  = 48'h0F0F0F0F0F0F;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned pcyc = 0;
  logic [2:0]  exp_q[$];
  int unsigned cyc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) pcyc <= pcyc + 1;

  // Scoreboard: each queued lookup must produce its result exactly one cycle after issue.
  always @(negedge clk) begin
    logic [2:0]  e;
    if (cyc_q.size() > 0 && cyc_q[0] + 1 == pcyc) begin
      e = exp_q.pop_front();
      void'(cyc_q.pop_front());
      check_eq("lookup_valid", lookup_valid_o, 1);
      if (lookup_valid_o) begin
        check_eq("lookup_hit", lookup_hit_o, e[2]);
        check_eq("lookup_port", lookup_port_o, e[1:0]);
      end
    end else if (lookup_valid_o) begin
      check_eq("lookup_valid_spurious", lookup_valid_o, 0);
    end
  end

  task automatic do_learn(input logic [47:0] a, input logic [1:0] p, input logic exp_ev);
    learn_req_i = 1'b1; learn_address_i = a; learn_port_i = p;
    @(negedge clk);
    learn_req_i = 1'b0;
    check_eq("evict", evict_o, exp_ev);
  endtask

  task automatic do_lookup(input logic [47:0] a, input logic hit, input logic [1:0] p);
    lookup_req_i = 1'b1; lookup_address_i = a;
    exp_q.push_back({hit, p});
    cyc_q.push_back(pcyc);
    @(negedge clk);
    lookup_req_i = 1'b0;
  endtask

  task automatic wait_scan(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq(tag, n, NE);
  endtask

  task automatic do_tick();
    age_tick_i = 1'b1;
    @(negedge clk);
    age_tick_i = 1'b0;
    wait_scan("age_scan_len");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_lookup_valid", lookup_valid_o, 0);
    check_eq("rst_lookup_hit", lookup_hit_o, 0);
    check_eq("rst_lookup_port", lookup_port_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_evict", evict_o, 0);
    check_eq("rst_count", entry_count_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic learn / hit / miss
    do_learn(A, 2'd2, 1'b0);
    check_eq("count_a", entry_count_o, 1);
    do_lookup(A, 1'b1, 2'd2);
    do_lookup(B, 1'b0, 2'd0);

    // station move keeps a single entry
    do_learn(A, 2'd1, 1'b0);
    do_learn(A, 2'd3, 1'b0);
    check_eq("count_move", entry_count_o, 1);
    do_lookup(A, 1'b1, 2'd3);

    // same-cycle learn and lookup: lookup sees old table
    learn_req_i = 1'b1; learn_address_i = C; learn_port_i = 2'd0;
    lookup_req_i = 1'b1; lookup_address_i = C;
    exp_q.push_back(3'b000); cyc_q.push_back(pcyc);
    @(negedge clk);
    learn_req_i = 1'b0; lookup_req_i = 1'b0;
    do_lookup(C, 1'b1, 2'd0);
    check_eq("count_c", entry_count_o, 2);

    // aging with AGE_MAX=3: survives two ticks, gone after the third
    do_tick();
    do_lookup(A, 1'b1, 2'd3);
    do_tick();
    do_lookup(A, 1'b1, 2'd3);
    do_tick();
    do_lookup(A, 1'b0, 2'd0);
    do_lookup(C, 1'b0, 2'd0);
    check_eq("count_aged_out", entry_count_o, 0);

    // fill, age, refresh 1..3, new learn evicts index 0
    do_learn(A0, 2'd0, 1'b0);
    do_learn(A1, 2'd1, 1'b0);
    do_learn(A2, 2'd2, 1'b0);
    do_learn(A3, 2'd3, 1'b0);
    check_eq("count_full", entry_count_o, 4);
    do_tick();
    do_learn(A1, 2'd1, 1'b0);
    do_learn(A2, 2'd2, 1'b0);
    do_learn(A3, 2'd3, 1'b0);
    do_learn(E, 2'd1, 1'b1);
    @(negedge clk);
    check_eq("evict_one_cycle", evict_o, 0);
    do_lookup(A0, 1'b0, 2'd0);
    do_lookup(E, 1'b1, 2'd1);
    do_lookup(A1, 1'b1, 2'd1);
    check_eq("count_after_evict", entry_count_o, 4);
    // all ages tied: lowest index (where E went) is the victim
    do_learn(F, 2'd0, 1'b1);
    do_lookup(E, 1'b0, 2'd0);
    do_lookup(F, 1'b1, 2'd0);
    do_lookup(A3, 1'b1, 2'd3);

    // ports 0,1,0,2 then flush port 0 with tick/flush injected mid-scan
    do_learn(A2, 2'd0, 1'b0);
    do_learn(A3, 2'd2, 1'b0);
    check_eq("count_pre_flush", entry_count_o, 4);
    flush_req_i = 1'b1; flush_port_i = 2'd0;
    @(negedge clk);
    flush_req_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      if (n == 2) begin
        age_tick_i = 1'b1; flush_req_i = 1'b1; flush_port_i = 2'd1;
      end
      @(negedge clk);
      age_tick_i = 1'b0; flush_req_i = 1'b0;
    end
    check_eq("flush_scan_len", n, NE);
    @(negedge clk);
    check_eq("busy_ignored_req", busy_o, 0);
    check_eq("count_post_flush", entry_count_o, 2);
    do_lookup(F, 1'b0, 2'd0);
    do_lookup(A2, 1'b0, 2'd0);
    do_lookup(A1, 1'b1, 2'd1);
    do_lookup(A3, 1'b1, 2'd2);

    // flush and tick together: flush wins, tick dropped (A3 keeps age 3)
    flush_req_i = 1'b1; flush_port_i = 2'd1; age_tick_i = 1'b1;
    @(negedge clk);
    flush_req_i = 1'b0; age_tick_i = 1'b0;
    wait_scan("flush_tick_scan_len");
    check_eq("count_flush_p1", entry_count_o, 1);
    do_tick();
    do_tick();
    do_lookup(A3, 1'b1, 2'd2);

    // A3 now age 1 at index 3: learn during its scan slot wins
    age_tick_i = 1'b1;
    @(negedge clk);
    age_tick_i = 1'b0;
    repeat (3) @(negedge clk);
    do_learn(A3, 2'd1, 1'b0);
    check_eq("busy_after_learn_scan", busy_o, 0);
    check_eq("count_learn_wins", entry_count_o, 1);
    do_lookup(A3, 1'b1, 2'd1);

    // reset mid age-scan
    do_learn(E, 2'd0, 1'b0);
    check_eq("count_pre_rst", entry_count_o, 2);
    age_tick_i = 1'b1;
    @(negedge clk);
    age_tick_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_count", entry_count_o, 0);
    check_eq("midrst_lookup_valid", lookup_valid_o, 0);
    rst = 1'b0;
    do_lookup(E, 1'b0, 2'd0);
    do_lookup(A3, 1'b0, 2'd0);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
